// File: rtl/io_intr_bridge.sv
// Peripheral-side bridge: queues processor send words toward the MAC transmitter
// and serializes key / Ethernet receive events into one-at-a-time interrupts.
package io_intr_bridge_pkg;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned KEY_W  = 8;

  typedef enum logic [1:0] {
    IRQ_IDLE = 2'd0,
    IRQ_FIRE = 2'd1,
    IRQ_WAIT = 2'd2,
    IRQ_GAP  = 2'd3
  } irq_state_e;

  typedef enum logic {
    SRC_KEY = 1'b0,
    SRC_ETH = 1'b1
  } evt_src_e;

  typedef struct packed {
    evt_src_e          src;
    logic [DATA_W-1:0] data;
  } evt_t;
endpackage

module io_intr_bridge
  import io_intr_bridge_pkg::*;
#(
  parameter int unsigned TX_DEPTH  = 4,
  parameter int unsigned EVT_DEPTH = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              snd,
  input  logic [DATA_W-1:0] interface_data,
  input  logic              int_ack,
  input  logic              key_valid,
  input  logic [KEY_W-1:0]  key_code,
  input  logic              eth_rx_valid,
  input  logic [DATA_W-1:0] eth_rx_data,
  output logic              eth_rx_ready,
  output logic              eth_tx_valid,
  output logic [DATA_W-1:0] eth_tx_data,
  input  logic              eth_tx_ready,
  output logic              interrupt_key,
  output logic              interrupt_eth,
  output logic [DATA_W-1:0] interrupt_source_data,
  output logic              tx_overflow,
  output logic              key_overflow
);

  localparam int unsigned TX_AW  = $clog2(TX_DEPTH);
  localparam int unsigned TX_PW  = TX_AW + 1;
  localparam int unsigned EVT_AW = $clog2(EVT_DEPTH);
  localparam int unsigned EVT_PW = EVT_AW + 1;

  // ---------------------------------------------------------------- TX FIFO
  logic [DATA_W-1:0] tx_mem [TX_DEPTH];
  logic [TX_PW-1:0]  tx_wr_ptr;
  logic [TX_PW-1:0]  tx_rd_ptr;
  logic              tx_empty;
  logic              tx_full;
  logic              tx_push;
  logic              tx_pop;

  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  always_comb begin
    tx_empty = (tx_wr_ptr == tx_rd_ptr);
    tx_full  = (tx_wr_ptr[TX_AW] != tx_rd_ptr[TX_AW]) &&
               (tx_wr_ptr[TX_AW-1:0] == tx_rd_ptr[TX_AW-1:0]);
    tx_pop   = !tx_empty && eth_tx_ready;
    tx_push  = snd && (!tx_full || tx_pop);
  end

  assign eth_tx_valid = !tx_empty;
  assign eth_tx_data  = tx_empty ? '0 : tx_mem[tx_rd_ptr[TX_AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_wr_ptr   <= '0;
      tx_rd_ptr   <= '0;
      tx_overflow <= 1'b0;
    end else begin
      if (tx_push) tx_wr_ptr <= tx_wr_ptr + TX_PW'(1);
      if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + TX_PW'(1);
      if (snd && !tx_push) tx_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr_ptr[TX_AW-1:0]] <= interface_data;
  end

  // ------------------------------------------------------------- event FIFO
  evt_t              evt_mem [EVT_DEPTH];
  logic [EVT_PW-1:0] evt_wr_ptr;
  logic [EVT_PW-1:0] evt_rd_ptr;
  logic              evt_empty;
  logic              evt_full;
  logic              evt_push;
  logic              evt_pop;
  logic              key_push;
  logic              eth_push;
  evt_t              evt_din;
  evt_t              evt_head;
  logic              rx_en;
  irq_state_e        state;

  // Key wins the single push slot; the Ethernet side is throttled via eth_rx_ready.
  always_comb begin
    evt_empty    = (evt_wr_ptr == evt_rd_ptr);
    evt_full     = (evt_wr_ptr[EVT_AW] != evt_rd_ptr[EVT_AW]) &&
                   (evt_wr_ptr[EVT_AW-1:0] == evt_rd_ptr[EVT_AW-1:0]);
    evt_pop      = (state == IRQ_WAIT) && int_ack;
    key_push     = key_valid && (!evt_full || evt_pop);
    eth_push     = eth_rx_valid && eth_rx_ready;
    evt_push     = key_push || eth_push;
    evt_din.src  = SRC_ETH;
    evt_din.data = eth_rx_data;
    if (key_valid) begin
      evt_din.src  = SRC_KEY;
      evt_din.data = DATA_W'(key_code);
    end
    evt_head = evt_mem[evt_rd_ptr[EVT_AW-1:0]];
  end

  assign eth_rx_ready = rx_en && !evt_full && !key_valid;

  // Keeps eth_rx_ready low while reset is applied.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rx_en <= 1'b0;
    else        rx_en <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_wr_ptr   <= '0;
      evt_rd_ptr   <= '0;
      key_overflow <= 1'b0;
    end else begin
      if (evt_push) evt_wr_ptr <= evt_wr_ptr + EVT_PW'(1);
      if (evt_pop)  evt_rd_ptr <= evt_rd_ptr + EVT_PW'(1);
      if (key_valid && !key_push) key_overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (evt_push) evt_mem[evt_wr_ptr[EVT_AW-1:0]] <= evt_din;
  end

  // --------------------------------------------------------- interrupt FSM
  // Head stays in the FIFO until acknowledged; GAP lets the processor latch clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state                 <= IRQ_IDLE;
      interrupt_key         <= 1'b0;
      interrupt_eth         <= 1'b0;
      interrupt_source_data <= '0;
    end else begin
      interrupt_key <= 1'b0;
      interrupt_eth <= 1'b0;
      case (state)
        IRQ_IDLE: begin
          if (!evt_empty) begin
            state                 <= IRQ_FIRE;
            interrupt_key         <= (evt_head.src == SRC_KEY);
            interrupt_eth         <= (evt_head.src == SRC_ETH);
            interrupt_source_data <= evt_head.data;
          end
        end
        IRQ_FIRE: state <= IRQ_WAIT;
        IRQ_WAIT: if (int_ack) state <= IRQ_GAP;
        IRQ_GAP:  state <= IRQ_IDLE;
        default:  state <= IRQ_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_io_intr_bridge.sv
// Bench for io_intr_bridge: interrupt scoreboard plus table-driven TX path vectors.
module tb_io_intr_bridge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        snd = 1'b0;
  logic [31:0] interface_data = '0;
  logic        int_ack = 1'b0;
  logic        key_valid = 1'b0;
  logic [7:0]  key_code = '0;
  logic        eth_rx_valid = 1'b0;
  logic [31:0] eth_rx_data = '0;
  logic        eth_rx_ready;
  logic        eth_tx_valid;
  logic [31:0] eth_tx_data;
  logic        eth_tx_ready = 1'b0;
  logic        interrupt_key;
  logic        interrupt_eth;
  logic [31:0] interrupt_source_data;
  logic        tx_overflow;
  logic        key_overflow;

  int n_checks = 0;
  int n_fail   = 0;
  int irq_seen = 0;

  typedef struct packed {
    logic        src;
    logic [31:0] data;
  } irq_exp_t;

  typedef struct packed {
    logic        rst;
    logic        snd;
    logic [31:0] d;
    logic        rdy;
    logic        exp_valid;
    logic [31:0] exp_data;
    logic        exp_ovf;
  } tx_vec_t;

  irq_exp_t irq_q[$];
  tx_vec_t  tv[$];

  io_intr_bridge #(.TX_DEPTH(4), .EVT_DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .snd(snd), .interface_data(interface_data),
    .int_ack(int_ack), .key_valid(key_valid), .key_code(key_code),
    .eth_rx_valid(eth_rx_valid), .eth_rx_data(eth_rx_data), .eth_rx_ready(eth_rx_ready),
    .eth_tx_valid(eth_tx_valid), .eth_tx_data(eth_tx_data), .eth_tx_ready(eth_tx_ready),
    .interrupt_key(interrupt_key), .interrupt_eth(interrupt_eth),
    .interrupt_source_data(interrupt_source_data),
    .tx_overflow(tx_overflow), .key_overflow(key_overflow)
  );

  always #5 clk = ~clk;

  function automatic irq_exp_t mk_irq(input logic src, input logic [31:0] data);
    irq_exp_t e;
    e.src  = src;
    e.data = data;
    return e;
  endfunction

  function automatic tx_vec_t mk_tx(input logic rst, input logic s, input logic [31:0] d,
                                    input logic rdy, input logic ev, input logic [31:0] ed,
                                    input logic eo);
    tx_vec_t v;
    v.rst = rst; v.snd = s; v.d = d; v.rdy = rdy;
    v.exp_valid = ev; v.exp_data = ed; v.exp_ovf = eo;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_irq_key"},  32'(interrupt_key), 32'd0);
    chk({tag, "_irq_eth"},  32'(interrupt_eth), 32'd0);
    chk({tag, "_src_data"}, interrupt_source_data, 32'd0);
    chk({tag, "_tx_valid"}, 32'(eth_tx_valid), 32'd0);
    chk({tag, "_tx_data"},  eth_tx_data, 32'd0);
    chk({tag, "_tx_ovf"},   32'(tx_overflow), 32'd0);
    chk({tag, "_key_ovf"},  32'(key_overflow), 32'd0);
    chk({tag, "_rx_ready"}, 32'(eth_rx_ready), 32'd0);
  endtask

  // Waits (bounded) for the next interrupt pulse, then acks after ack_delay WAIT cycles.
  task automatic service(input int ack_delay);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (interrupt_key || interrupt_eth) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      n_checks++;
      n_fail++;
      $display("FAIL irq_timeout: no interrupt within 40 cycles, expected one");
    end
    tick();
    repeat (ack_delay) tick();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
  endtask

  // Scoreboard: every interrupt pulse must match the oldest expected event.
  always @(negedge clk) begin : irq_mon
    irq_exp_t e;
    if (rst_n && (interrupt_key || interrupt_eth)) begin
      irq_seen++;
      if (irq_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_irq: got key=%0b eth=%0b data=%h, expected no interrupt",
                 interrupt_key, interrupt_eth, interrupt_source_data);
      end else begin
        e = irq_q.pop_front();
        chk("irq_key",  32'(interrupt_key), 32'(e.src == 1'b0));
        chk("irq_eth",  32'(interrupt_eth), 32'(e.src == 1'b1));
        chk("irq_data", interrupt_source_data, e.data);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // TX path vectors: backpressure/overflow, then full FIFO with simultaneous push+pop
    tv.push_back(mk_tx(1, 1, 32'd1, 0, 0, 32'd0, 0));
    tv.push_back(mk_tx(0, 1, 32'd2, 0, 1, 32'd1, 0));
    tv.push_back(mk_tx(0, 1, 32'd3, 0, 1, 32'd1, 0));
    tv.push_back(mk_tx(0, 1, 32'd4, 0, 1, 32'd1, 0));
    tv.push_back(mk_tx(0, 1, 32'd5, 0, 1, 32'd1, 0));
    tv.push_back(mk_tx(0, 0, 32'd0, 1, 1, 32'd1, 1));
    tv.push_back(mk_tx(0, 0, 32'd0, 1, 1, 32'd2, 1));
    tv.push_back(mk_tx(0, 0, 32'd0, 1, 1, 32'd3, 1));
    tv.push_back(mk_tx(0, 0, 32'd0, 1, 1, 32'd4, 1));
    tv.push_back(mk_tx(0, 0, 32'd0, 1, 0, 32'd0, 1));
    tv.push_back(mk_tx(1, 1, 32'h10, 0, 0, 32'd0, 0));
    tv.push_back(mk_tx(0, 1, 32'h11, 0, 1, 32'h10, 0));
    tv.push_back(mk_tx(0, 1, 32'h12, 0, 1, 32'h10, 0));
    tv.push_back(mk_tx(0, 1, 32'h13, 0, 1, 32'h10, 0));
    tv.push_back(mk_tx(0, 1, 32'hA5A5A5A5, 1, 1, 32'h10, 0));
    tv.push_back(mk_tx(0, 0, 32'd0, 1, 1, 32'h11, 0));
    tv.push_back(mk_tx(0, 0, 32'd0, 1, 1, 32'h12, 0));
    tv.push_back(mk_tx(0, 0, 32'd0, 1, 1, 32'h13, 0));
    tv.push_back(mk_tx(0, 0, 32'd0, 1, 1, 32'hA5A5A5A5, 0));
    tv.push_back(mk_tx(0, 0, 32'd0, 1, 0, 32'd0, 0));

    // Reset state
    #2 rst_n = 1'b0;
    #2 chk_all_zero("reset");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    tick();

    // Single key event with cycle-exact FIRE/WAIT/GAP timing
    irq_q.push_back(mk_irq(1'b0, 32'h41));
    key_valid = 1'b1;
    key_code  = 8'h41;
    tick();
    key_valid = 1'b0;
    key_code  = '0;
    sample();
    chk("t1_c1_no_irq", 32'(interrupt_key), 32'd0);
    tick();
    sample();
    chk("t1_fire_key",  32'(interrupt_key), 32'd1);
    chk("t1_fire_data", interrupt_source_data, 32'h41);
    tick();
    sample();
    chk("t1_wait_key",  32'(interrupt_key), 32'd0);
    chk("t1_wait_data", interrupt_source_data, 32'h41);
    tick();
    tick();
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    sample();
    chk("t1_gap_key",  32'(interrupt_key), 32'd0);
    chk("t1_gap_data", interrupt_source_data, 32'h41);
    irq_seen = 0;
    repeat (12) tick();
    chk("t1_no_more_irq", 32'(irq_seen), 32'd0);
    chk("t1_queue_empty", 32'(irq_q.size()), 32'd0);

    // Simultaneous key + eth: key first, eth word accepted one cycle later
    irq_q.push_back(mk_irq(1'b0, 32'h10));
    irq_q.push_back(mk_irq(1'b1, 32'hDEADBEEF));
    key_valid    = 1'b1;
    key_code     = 8'h10;
    eth_rx_valid = 1'b1;
    eth_rx_data  = 32'hDEADBEEF;
    sample();
    chk("t2_rx_ready_blocked", 32'(eth_rx_ready), 32'd0);
    tick();
    key_valid = 1'b0;
    sample();
    chk("t2_rx_ready_next", 32'(eth_rx_ready), 32'd1);
    tick();
    eth_rx_valid = 1'b0;
    service(1);
    service(0);
    repeat (6) tick();
    chk("t2_queue_empty", 32'(irq_q.size()), 32'd0);

    // Event overflow: 9 keys while the first one sits in WAIT
    irq_seen = 0;
    for (int i = 0; i < 8; i++) irq_q.push_back(mk_irq(1'b0, 32'(8'h60 + i)));
    key_valid = 1'b1;
    for (int i = 0; i < 9; i++) begin
      key_code = 8'(8'h60 + i);
      tick();
    end
    key_valid    = 1'b0;
    eth_rx_valid = 1'b1;
    eth_rx_data  = 32'h12345678;
    sample();
    chk("t5_key_ovf", 32'(key_overflow), 32'd1);
    chk("t5_rx_ready_full0", 32'(eth_rx_ready), 32'd0);
    tick();
    sample();
    chk("t5_rx_ready_full1", 32'(eth_rx_ready), 32'd0);
    tick();
    eth_rx_valid = 1'b0;
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    for (int i = 0; i < 7; i++) service(i % 3);
    repeat (10) tick();
    chk("t5_irq_count", 32'(irq_seen), 32'd8);
    chk("t5_queue_empty", 32'(irq_q.size()), 32'd0);

    // Spurious ack in IDLE with an empty FIFO
    irq_seen = 0;
    int_ack = 1'b1;
    tick();
    int_ack = 1'b0;
    repeat (8) tick();
    chk("t6_idle_ack_no_irq", 32'(irq_seen), 32'd0);

    // Spurious ack in IDLE with a non-empty FIFO must not pop
    irq_q.push_back(mk_irq(1'b0, 32'h81));
    irq_q.push_back(mk_irq(1'b0, 32'h82));
    key_valid = 1'b1;
    key_code  = 8'h81;
    tick();
    key_code = 8'h82;
    int_ack  = 1'b1;
    tick();
    key_valid = 1'b0;
    int_ack   = 1'b0;
    service(0);
    service(2);
    repeat (8) tick();
    chk("t6_ack_queue_empty", 32'(irq_q.size()), 32'd0);

    // Reset in WAIT with three queued events and a pending TX word
    irq_q.push_back(mk_irq(1'b0, 32'h71));
    snd            = 1'b1;
    interface_data = 32'hCAFE0001;
    eth_tx_ready   = 1'b0;
    key_valid      = 1'b1;
    key_code       = 8'h71;
    tick();
    snd      = 1'b0;
    key_code = 8'h72;
    tick();
    key_code = 8'h73;
    tick();
    key_valid = 1'b0;
    tick();
    chk("t6_tx_pending", 32'(eth_tx_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("t6_rst");
    irq_q.delete();
    tick();
    tick();
    rst_n = 1'b1;
    irq_seen = 0;
    repeat (20) tick();
    chk("t6_post_rst_no_irq", 32'(irq_seen), 32'd0);
    chk("t6_post_rst_tx_empty", 32'(eth_tx_valid), 32'd0);
    irq_q.push_back(mk_irq(1'b0, 32'h99));
    key_valid = 1'b1;
    key_code  = 8'h99;
    tick();
    key_valid = 1'b0;
    service(0);
    repeat (6) tick();
    chk("t6_new_event_served", 32'(irq_q.size()), 32'd0);

    // TX path table
    for (int i = 0; i < tv.size(); i++) begin
      if (tv[i].rst) do_reset();
      snd            = tv[i].snd;
      interface_data = tv[i].d;
      eth_tx_ready   = tv[i].rdy;
      sample();
      chk($sformatf("tx_valid[%0d]", i), 32'(eth_tx_valid), 32'(tv[i].exp_valid));
      chk($sformatf("tx_data[%0d]", i),  eth_tx_data, tv[i].exp_data);
      chk($sformatf("tx_ovf[%0d]", i),   32'(tx_overflow), 32'(tv[i].exp_ovf));
      tick();
    end
    snd          = 1'b0;
    eth_tx_ready = 1'b0;
    repeat (4) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/io_intr_bridge.md
Name: io_intr_bridge

Overview:
- Peripheral-side counterpart of the processor's external interface.
- Takes processor send requests (snd + interface_data) and queues them toward the Ethernet MAC transmitter.
- Collects keyboard and Ethernet receive events into an event FIFO and presents them to the processor one at a time: interrupt_key / interrupt_eth pulse, with interrupt_source_data held stable until acknowledged.
- Sits between the processor top level and the key/MAC peripherals.

Parameters:
TX_DEPTH, 4, TX FIFO entries (power of 2, >=2)
EVT_DEPTH, 8, event FIFO entries (power of 2, >=2)

Ports:
clk  in  1  clock
rst_n  in  1  async active-low reset
snd  in  1  processor send strobe, one cycle per word
interface_data  in  32  word to send, sampled when snd=1
int_ack  in  1  one-cycle pulse from top level on RTI/RSI retire
key_valid  in  1  key event strobe, no backpressure
key_code  in  8  key code, sampled when key_valid=1
eth_rx_valid  in  1  MAC receive word valid
eth_rx_data  in  32  MAC receive word
eth_rx_ready  out  1  bridge can accept receive word
eth_tx_valid  out  1  TX FIFO head valid
eth_tx_data  out  32  TX FIFO head word
eth_tx_ready  in  1  MAC accepts head word
interrupt_key  out  1  one-cycle interrupt pulse, key source
interrupt_eth  out  1  one-cycle interrupt pulse, Ethernet source
interrupt_source_data  out  32  payload of event under service
tx_overflow  out  1  sticky: snd dropped on full TX FIFO
key_overflow  out  1  sticky: key event dropped on full event FIFO

Behaviour:

Reset:
- All outputs 0; both FIFOs empty; FSM in IDLE; sticky flags cleared.
- Reset asserted mid-operation discards all queued data.

TX path:
- snd=1 and TX FIFO not full: push interface_data.
- snd=1 and TX FIFO full: word dropped; tx_overflow<=1.
- eth_tx_valid = TX FIFO not empty; eth_tx_data = head word (first-word-fall-through).
- eth_tx_valid & eth_tx_ready pops the head.
- Push and pop in the same cycle are both allowed when full: the pop frees the slot, so the push is accepted and no overflow occurs.
- A push into an empty FIFO is visible on eth_tx_valid the next cycle.
- Pointer widths are clog2(depth)+1; wrap is modulo depth.

Event FIFO:
- Entry format {src, data32}: src=0 key, 1 eth. Key data = {24'h0, key_code}.
- At most one push per cycle. Key has priority.
- eth_rx_ready = FIFO not full AND key_valid=0 (combinational).
- eth_rx_valid & eth_rx_ready pushes the Ethernet word.
- key_valid with FIFO full: event dropped; key_overflow<=1.
- The pop from the interrupt FSM (below) counts toward occupancy in the same cycle: a full FIFO with a pop accepts a push.

Interrupt FSM:
- IDLE: if event FIFO not empty -> FIRE.
- FIRE (1 cycle):
  - interrupt_key=1 if head src=0, else interrupt_eth=1.
  - interrupt_source_data <= head data; it is driven from FIRE through the ack cycle.
  - -> WAIT.
- WAIT: hold interrupt_source_data. On int_ack=1: pop head -> GAP.
- GAP (1 cycle): interrupt outputs low; ensures the processor interrupt latch has cleared. -> IDLE.
- int_ack outside WAIT is ignored.
- Minimum spacing between consecutive interrupt pulses is 4 cycles (FIRE, WAIT>=1, GAP, IDLE).
- interrupt_source_data retains its last value in IDLE/GAP; it is not cleared.

Sticky flags:
- Cleared only by reset.

Test Plan:
1. Single key event:
   - Stimulus: key_valid=1, key_code=8'h41 in cycle 0.
   - Required: event FIFO non-empty in cycle 1; FSM in FIRE in cycle 2, with interrupt_key=1 for exactly that cycle and interrupt_source_data=32'h00000041.
   - Required: int_ack in cycle 5 -> GAP in cycle 6, IDLE in cycle 7, no further interrupt.
2. Simultaneous key + eth:
   - Stimulus: key_valid with code 8'h10 and eth_rx_valid with data 32'hDEADBEEF in the same cycle.
   - Required: eth_rx_ready=0 that cycle; eth word accepted the next cycle.
   - Required: key interrupt serviced first (data 32'h10); after its ack, interrupt_eth fires with 32'hDEADBEEF.
3. TX backpressure:
   - Stimulus: 5 snd pulses (words 1..5) with eth_tx_ready=0 and TX_DEPTH=4.
   - Required: word 5 dropped and tx_overflow=1.
   - Required: after eth_tx_ready=1, eth_tx_data sequence is 1,2,3,4, then eth_tx_valid=0.
4. Full-FIFO push+pop:
   - Stimulus: TX FIFO full with eth_tx_ready=1, and snd with 32'hA5A5A5A5 in the same cycle.
   - Required: accepted; tx_overflow stays 0; 32'hA5A5A5A5 emerges last.
5. Event overflow:
   - Stimulus: 9 key events while the FSM sits in WAIT with no ack (EVT_DEPTH=8).
   - Required: key_overflow=1.
   - Required: eth_rx_ready stays 0 while the FIFO is full.
   - Required: after 8 acks, exactly 8 interrupts have been delivered, in order.
6. Spurious ack and reset mid-WAIT:
   - Stimulus: int_ack pulse in IDLE.
   - Required: no pop, no state change.
   - Stimulus: assert rst_n=0 while in WAIT with 3 queued events.
   - Required: all outputs 0 immediately; no interrupt fires after release until new events arrive.
